// File: rtl/reg_dump_engine_if.sv
// Bus bundle for reg_dump_engine: register-file read port plus the
// valid/ready output stream. The engine uses the master modport.
interface reg_dump_engine_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic [AW-1:0]   rf_addr;
  logic [XLEN-1:0] rf_data;
  logic            m_valid;
  logic            m_ready;
  logic [XLEN-1:0] m_data;
  logic [AW-1:0]   m_addr;
  logic            m_last;

  modport master (
    output rf_addr,
    input  rf_data,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_addr,
    output m_last
  );

  modport slave (
    input  rf_addr,
    output rf_data,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_addr,
    input  m_last
  );
endinterface

// File: rtl/reg_dump_engine.sv
// Register-file dump engine: walks [first, last] through one read port and
// streams each value tagged with its index. Optional trailing XOR checksum
// beat is enabled by defining REG_DUMP_CKSUM_EN.
module reg_dump_engine #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [AW-1:0]            first_addr_i,
  input  logic [AW-1:0]            last_addr_i,
  input  logic                     abort_i,
  reg_dump_engine_if.master        bus_io,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   last_q, last_d;
  logic            abort_pend_q, abort_pend_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            mlast_q, mlast_d;
  logic            abort_now;
`ifdef REG_DUMP_CKSUM_EN
  logic [XLEN-1:0] cksum_q, cksum_d;
  logic            fin_q, fin_d;        // beat in SEND is the last data index
  logic            ck_beat_q, ck_beat_d; // beat in SEND is the checksum beat
`endif

  // An abort arriving on the handshake edge counts the same as a pending one.
  assign abort_now = abort_pend_q | abort_i;

  // Next-state and datapath loads.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    last_d       = last_q;
    abort_pend_d = abort_pend_q;
    err_d        = err_q;
    data_d       = data_q;
    addr_d       = addr_q;
    mlast_d      = mlast_q;
`ifdef REG_DUMP_CKSUM_EN
    cksum_d      = cksum_q;
    fin_d        = fin_q;
    ck_beat_d    = ck_beat_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          ptr_d        = first_addr_i;
          last_d       = last_addr_i;
          abort_pend_d = 1'b0;
          err_d        = (first_addr_i > last_addr_i);
`ifdef REG_DUMP_CKSUM_EN
          cksum_d      = '0;
          ck_beat_d    = 1'b0;
`endif
          state_d      = (first_addr_i > last_addr_i) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (abort_i) begin
          state_d = StDone;
        end else begin
          data_d  = bus_io.rf_data;
          addr_d  = ptr_q;
`ifdef REG_DUMP_CKSUM_EN
          fin_d   = (ptr_q == last_q);
          mlast_d = 1'b0;
`else
          mlast_d = (ptr_q == last_q);
`endif
          state_d = StSend;
        end
      end
      StSend: begin
        if (abort_i) abort_pend_d = 1'b1;
        if (bus_io.m_ready) begin
`ifdef REG_DUMP_CKSUM_EN
          cksum_d = cksum_q ^ data_q;
          if (ck_beat_q || abort_now) begin
            state_d = StDone;
          end else if (fin_q) begin
            // Stay in SEND and present the checksum as one more beat.
            data_d    = cksum_q ^ data_q;
            addr_d    = '0;
            mlast_d   = 1'b1;
            ck_beat_d = 1'b1;
          end else begin
            ptr_d   = ptr_q + AW'(1);
            state_d = StFetch;
          end
`else
          if (mlast_q || abort_now) begin
            state_d = StDone;
          end else begin
            ptr_d   = ptr_q + AW'(1);
            state_d = StFetch;
          end
`endif
        end
      end
      StDone: begin
        state_d      = StIdle;
        err_d        = 1'b0;
        abort_pend_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset drops any beat in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      last_q       <= '0;
      abort_pend_q <= 1'b0;
      err_q        <= 1'b0;
      data_q       <= '0;
      addr_q       <= '0;
      mlast_q      <= 1'b0;
`ifdef REG_DUMP_CKSUM_EN
      cksum_q      <= '0;
      fin_q        <= 1'b0;
      ck_beat_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      last_q       <= last_d;
      abort_pend_q <= abort_pend_d;
      err_q        <= err_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      mlast_q      <= mlast_d;
`ifdef REG_DUMP_CKSUM_EN
      cksum_q      <= cksum_d;
      fin_q        <= fin_d;
      ck_beat_q    <= ck_beat_d;
`endif
    end
  end

  // Outputs decode from registered state only, so m_ready never reaches them.
  always_comb begin
    bus_io.rf_addr = (state_q == StFetch) ? ptr_q : '0;
    bus_io.m_valid = (state_q == StSend);
    bus_io.m_data  = data_q;
    bus_io.m_addr  = addr_q;
    bus_io.m_last  = mlast_q;
    busy_o         = (state_q != StIdle);
    done_o         = (state_q == StDone);
    err_o          = (state_q == StDone) & err_q;
  end

endmodule

// File: tb/tb_reg_dump_engine.sv
// Self-checking bench for reg_dump_engine. Expected beat lists come from a
// range/abort/checksum model over the bench's own register-file array.
module tb_reg_dump_engine;

`ifdef REG_DUMP_CKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  first_addr = '0;
  logic [4:0]  last_addr = '0;
  logic        abort = 1'b0;
  logic        busy, done, err;
  logic        ready_mode = 1'b0;
  logic        ready_fix = 1'b1;
  logic        rnd_bit = 1'b0;
  logic [31:0] rf_mem [32];

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    err_cnt = 0;
  int    done_cyc = 0;
  int    unstable = 0;
  beat_t got_q[$];
  beat_t exp_q[$];

  reg_dump_engine_if #(.XLEN(32), .AW(5)) bus ();

  assign bus.rf_data = rf_mem[bus.rf_addr];
  assign bus.m_ready = ready_mode ? rnd_bit : ready_fix;

  reg_dump_engine #(.XLEN(32), .AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .first_addr_i (first_addr),
    .last_addr_i  (last_addr),
    .abort_i      (abort),
    .bus_io       (bus),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Record handshakes and done/err pulses between edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid && bus.m_ready)
        got_q.push_back('{a: bus.m_addr, d: bus.m_data, l: bus.m_last});
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (err) err_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected beats: indices f..l (stopping after abort_at), checksum beat on
  // completed dumps when enabled, otherwise m_last on the final index.
  function automatic void model_dump(input int f, input int l, input int abort_at);
    logic [31:0] x;
    bit          ab;
    x  = '0;
    ab = 1'b0;
    exp_q.delete();
    for (int i = f; i <= l; i++) begin
      exp_q.push_back('{a: 5'(i), d: rf_mem[i], l: ((i == l) && !CkEn)});
      x ^= rf_mem[i];
      if (i == abort_at) begin
        ab = 1'b1;
        break;
      end
    end
    if (CkEn && !ab) exp_q.push_back('{a: 5'd0, d: x, l: 1'b1});
  endfunction

  // Pulse start, then steer m_ready (and optionally abort/start) until idle.
  task automatic drive_dump(input int f, input int l, input int hold_addr, input int hold_n,
                            input bit do_abort, input int restart_at, input int budget,
                            output int e0, output bit timed_out);
    logic [31:0] hd;
    logic [4:0]  ha;
    logic        hl;
    int          held;
    got_q.delete();
    unstable  = 0;
    held      = 0;
    timed_out = 1'b1;
    hd = '0; ha = '0; hl = 1'b0;
    ready_fix  = 1'b0;
    first_addr = 5'(f);
    last_addr  = 5'(l);
    start      = 1'b1;
    e0         = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      abort = 1'b0;
      start = 1'b0;
      if (c == restart_at) begin
        start      = 1'b1;
        first_addr = 5'd20;
        last_addr  = 5'd21;
      end
      if (held > 0 && held < hold_n) begin
        if (!(bus.m_valid === 1'b1 && bus.m_data === hd && bus.m_addr === ha &&
              bus.m_last === hl)) unstable++;
        ready_fix = 1'b0;
        held++;
      end else if (held == 0 && bus.m_valid && int'(bus.m_addr) == hold_addr) begin
        hd = bus.m_data; ha = bus.m_addr; hl = bus.m_last;
        abort     = do_abort;
        ready_fix = 1'b0;
        held      = 1;
      end else begin
        ready_fix = 1'b1;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_done_err got %b%b want 00", done, err); end
    checks++; if (bus.m_data !== 32'd0 || bus.m_addr !== 5'd0 || bus.m_last !== 1'b0) begin
      errors++; $display("FAIL rst_beat got d=%h a=%0d l=%b want 0", bus.m_data, bus.m_addr, bus.m_last);
    end
    checks++; if (bus.rf_addr !== 5'd0) begin errors++; $display("FAIL rst_rf_addr got %0d want 0", bus.rf_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b want 0", busy); end
  endtask

  task automatic test_full_dump();
    int e0, d0, r0, want_done;
    bit to;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i) * 32'h0101_0101;
    model_dump(0, 31, -1);
    d0 = done_cnt; r0 = err_cnt;
    drive_dump(0, 31, -1, 0, 1'b0, -1, 200, e0, to);
    checks++; if (to) begin errors++; $display("FAIL full_timeout busy still %b want 0", busy); end
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL full_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL full_beat%0d got a=%0d d=%h l=%b want a=%0d d=%h l=%b", i,
                           got_q[i].a, got_q[i].d, got_q[i].l, exp_q[i].a, exp_q[i].d, exp_q[i].l);
      end
    end
    want_done = e0 + 2 * (exp_q.size() - int'(CkEn)) + int'(CkEn);
    checks++; if (done_cnt - d0 != 1 || done_cyc != want_done) begin
      errors++; $display("FAIL full_done got pulses=%0d at %0d want 1 at %0d", done_cnt - d0, done_cyc, want_done);
    end
    checks++; if (err_cnt != r0) begin errors++; $display("FAIL full_err got %0d want 0", err_cnt - r0); end
  endtask

  task automatic test_stall();
    int e0;
    bit to;
    model_dump(4, 9, -1);
    drive_dump(4, 9, 6, 5, 1'b0, -1, 200, e0, to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout busy still %b want 0", busy); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", unstable); end
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stall_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_beat%0d got a=%0d d=%h want a=%0d d=%h", i,
                           got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic test_invalid_range();
    got_q.delete();
    first_addr = 5'd10;
    last_addr  = 5'd3;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL inv_pulse got done=%b err=%b want 1 1", done, err);
    end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL inv_valid got %b want 0", bus.m_valid); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL inv_after got done=%b err=%b busy=%b want 0 0 0", done, err, busy);
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL inv_beats got %0d want 0", got_q.size()); end
  endtask

  task automatic test_abort();
    int e0, d0;
    bit to;
    model_dump(0, 31, 7);
    d0 = done_cnt;
    drive_dump(0, 31, 7, 3, 1'b1, -1, 200, e0, to);
    checks++; if (to) begin errors++; $display("FAIL abort_timeout busy still %b want 0", busy); end
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL abort_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL abort_beat%0d got a=%0d d=%h l=%b want a=%0d d=%h l=%b", i,
                           got_q[i].a, got_q[i].d, got_q[i].l, exp_q[i].a, exp_q[i].d, exp_q[i].l);
      end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL abort_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_dump();
    bit seen;
    got_q.delete();
    ready_mode = 1'b0;
    ready_fix  = 1'b1;
    first_addr = 5'd0;
    last_addr  = 5'd31;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.m_valid && bus.m_addr == 5'd12) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL midrst_reach got seen=%b want 1", seen); end
    rst = 1'b1;
    #1;
    checks++; if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_ctl got valid=%b busy=%b want 0 0", bus.m_valid, busy);
    end
    checks++; if (bus.m_data !== 32'd0 || bus.m_addr !== 5'd0 || bus.m_last !== 1'b0) begin
      errors++; $display("FAIL midrst_beat got d=%h a=%0d l=%b want 0", bus.m_data, bus.m_addr, bus.m_last);
    end
    checks++; if (done !== 1'b0 || err !== 1'b0 || bus.rf_addr !== 5'd0) begin
      errors++; $display("FAIL midrst_misc got done=%b err=%b rf=%0d want 0", done, err, bus.rf_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got busy=%b want 0", busy); end
    checks++; if (got_q.size() != 12) begin errors++; $display("FAIL midrst_beats got %0d want 12", got_q.size()); end
  endtask

  task automatic test_start_while_busy();
    int e0, d0, n;
    bit to;
    model_dump(2, 5, -1);
    d0 = done_cnt;
    drive_dump(2, 5, -1, 0, 1'b0, 3, 100, e0, to);
    checks++; if (to) begin errors++; $display("FAIL busy_start_timeout busy still %b want 0", busy); end
    repeat (4) @(posedge clk);
    #1;
    n = got_q.size();
    checks++; if (n != exp_q.size() || busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_count got %0d busy=%b want %0d busy=0", n, busy, exp_q.size());
    end
    foreach (exp_q[i]) if (i < n) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL busy_start_beat%0d got a=%0d want a=%0d", i, got_q[i].a, exp_q[i].a);
      end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_start_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_random();
    int e0, f, l, d0;
    bit to;
    ready_mode = 1'b1;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? 32'd0 : $urandom;
      f = $urandom_range(0, 31);
      l = $urandom_range(f, 31);
      model_dump(f, l, -1);
      d0 = done_cnt;
      drive_dump(f, l, -1, 0, 1'b0, -1, 400, e0, to);
      checks++; if (to || got_q.size() != exp_q.size() || done_cnt - d0 != 1) begin
        errors++; $display("FAIL rand%0d_count [%0d:%0d] got %0d beats %0d done want %0d 1", t, f, l,
                           got_q.size(), done_cnt - d0, exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++; if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_beat%0d got a=%0d d=%h l=%b want a=%0d d=%h l=%b", t, i,
                             got_q[i].a, got_q[i].d, got_q[i].l, exp_q[i].a, exp_q[i].d, exp_q[i].l);
        end
      end
      @(posedge clk); #1;
    end
    ready_mode = 1'b0;
  endtask

`ifdef REG_DUMP_CKSUM_EN
  task automatic test_cksum();
    int e0;
    bit to;
    rf_mem[1] = 32'h0000_000A;
    rf_mem[2] = 32'h0000_0005;
    rf_mem[3] = 32'h0000_00F0;
    drive_dump(1, 3, -1, 0, 1'b0, -1, 100, e0, to);
    checks++; if (to || got_q.size() != 4) begin
      errors++; $display("FAIL cksum_count got %0d want 4", got_q.size());
    end
    if (got_q.size() == 4) begin
      checks++; if (got_q[3] !== beat_t'{a: 5'd0, d: 32'h0000_00FF, l: 1'b1}) begin
        errors++; $display("FAIL cksum_beat got a=%0d d=%h l=%b want a=0 d=000000ff l=1",
                           got_q[3].a, got_q[3].d, got_q[3].l);
      end
      checks++; if (got_q[2].l !== 1'b0) begin errors++; $display("FAIL cksum_lastdata got l=%b want 0", got_q[2].l); end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    test_reset();
    test_full_dump();
    test_stall();
    test_invalid_range();
    test_abort();
    test_reset_mid_dump();
    test_start_while_busy();
    test_random();
`ifdef REG_DUMP_CKSUM_EN
    test_cksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_dump_engine.md
# reg_dump_engine

Debug read-out engine for the 32×32 register file. On a start request it walks a contiguous register index range through one register-file read port and streams each value out over a valid/ready interface tagged with its index. It sits beside the core datapath and borrows a read port (A/RD pair) while `busy` is high. It gives debug and test logic the consumer side of the register file's read interface.

## Interface
Parameters:
- `XLEN`, 32, data word width
- `AW`, 5, register index width (32 registers)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  dump request; sampled only while idle
- `first_addr`  in  AW  first index to dump; captured on accepted `start`
- `last_addr`  in  AW  last index to dump, inclusive; captured on accepted `start`
- `abort`  in  1  stop the dump early
- `rf_addr`  out  AW  read address to the register file read port
- `rf_data`  in  XLEN  combinational read data returned for `rf_addr`
- `m_valid`  out  1  output beat valid
- `m_ready`  in  1  sink ready
- `m_data`  out  XLEN  register value
- `m_addr`  out  AW  index of `m_data`
- `m_last`  out  1  final beat of the dump
- `busy`  out  1  dump in progress; read port is owned by this block
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle pulse coincident with `done` for an empty (invalid) range

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE: `start`=1 is accepted. `first_addr` and `last_addr` are latched, and `ptr` is set to `first_addr`.
  - If `first_addr` > `last_addr`, the FSM goes to DONE with `err` set. No beats are sent.
  - Otherwise the FSM goes to FETCH.
- FETCH: `rf_addr`=`ptr`. At the closing edge, `rf_data` is registered into `m_data` and `ptr` into `m_addr`. `m_last` is set to (`ptr`==`last`). The FSM goes to SEND.
- SEND: `m_valid`=1.
  - `m_data`, `m_addr` and `m_last` are held stable until the handshake (`m_valid`&`m_ready` at a rising edge).
  - On handshake: if `m_last`, or an abort is pending, go to DONE. Otherwise `ptr`+1 and go to FETCH.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Abort handling:
  - `abort` in FETCH goes directly to DONE. No beat is produced.
  - `abort` in SEND sets an abort-pending flag. The current beat must still complete its handshake; `m_valid` never drops without one. The FSM goes to DONE after that handshake.
  - `m_last` is not forced on an aborted dump.
  - `abort` in IDLE or DONE is ignored.
- `start` while `busy` is ignored and is not queued.
- `ptr` never wraps: the range check guarantees `ptr` ≤ `last`. With `first`=0 and `last`=31, `ptr` stops at 31.
- `rf_addr` is 0 whenever the FSM is not in FETCH.
- The dump is not a snapshot. Writes the core makes during a dump are visible if they land before that register's FETCH.

## Timing
- Reset: state IDLE; `ptr`, abort-pending, `rf_addr`, `m_data`, `m_addr` and all 1-bit outputs are 0. Reset takes effect immediately and asynchronously, including mid-dump. A beat in flight is dropped.
- `start` accepted at edge E0: FETCH during E0–E1, and `m_valid` rises after E1.
- With `m_ready` tied to 1, there is one beat every 2 cycles. A handshake at edge En gives FETCH during the next cycle.
- `busy` is 1 from after E0 through the DONE cycle, then 0.
- `done` (and `err` if applicable) is high in the cycle after the final handshake.
- For an invalid range, `done`/`err` are high in the cycle after E0.
- The block adds no combinational path from `m_ready` to any output.

## Configuration
- `REG_DUMP_CKSUM_EN` defined:
  - After the last data beat of a completed (non-aborted) dump, one extra beat is sent in SEND.
  - That beat carries `m_data` = XOR of all data words sent, `m_addr`=0, `m_last`=1. The last data beat has `m_last`=0.
  - Aborted dumps send no checksum beat.
- Not defined: no checksum logic. `m_last` is on the last data beat.

## Test plan
- Preload xi = i·0x01010101 (x0=0); `first`=0, `last`=31, `m_ready`=1, no macro:
  - 32 beats, `m_addr` 0..31, `m_data` matches the preloaded values.
  - `m_last` only on index 31; `done` 1 cycle after the 32nd handshake (64 cycles after E0); `err`=0.
- `first`=4, `last`=9, `m_ready` low for 5 cycles while index 6 is valid:
  - `m_valid`/`m_data`/`m_addr` stable throughout.
  - 6 beats total, no duplicates or skips.
- `first`=10, `last`=3: no `m_valid`; `done`=`err`=1 in the cycle after E0.
- `first`=0, `last`=31, `abort` pulsed while index 7 is in SEND with `m_ready`=0, then `m_ready`=1:
  - Index 7 completes, no index 8; `m_last`=0; `done` pulses.
- `rst` asserted mid-dump at index 12: all outputs 0 at once, FSM IDLE. A `start` pulsed while `busy` is ignored.
- `REG_DUMP_CKSUM_EN`, `first`=1, `last`=3 (x1=0xA, x2=0x5, x3=0xF0):
  - 4 beats; the 4th has `m_data`=0xFF, `m_addr`=0, `m_last`=1.
